codeload_ctrl: RTL and testbench

Boot sequencer and owner of the code RAM write port. After reset it either skips loading (GPIO strap) or receives a program image over the UART receiver and writes it word by word into code RAM. It then releases the core from reset and hands the RAM port to the core's instruction/data side. It sits in the SoC between u_uart, the GPIO strap input, the core reset and the code RAM macro wrapper.

---
 rtl/codeload_if.sv | 34 +++
 rtl/codeload_ctrl.sv | 168 ++++++++++++++++
 tb/tb_codeload_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codeload_if.sv
// Boot-loader signal bundle: UART rx/tx handshake, core-side code-RAM request and code-RAM port.
// master = the loader (codeload_ctrl); slave = the SoC side (UART, core, RAM wrapper).
interface codeload_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  rx_data_valid;
    logic [7:0]            rx_data;
    logic                  rx_error;
    logic                  tx_busy;
    logic                  tx_data_valid;
    logic [7:0]            tx_data;
    logic                  core_ce;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [31:0]           core_wdata;
    logic                  ram_ce;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;

    modport master (
        input  rx_data_valid, rx_data, rx_error, tx_busy,
        input  core_ce, core_we, core_addr, core_wdata,
        output tx_data_valid, tx_data,
        output ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output rx_data_valid, rx_data, rx_error, tx_busy,
        output core_ce, core_we, core_addr, core_wdata,
        input  tx_data_valid, tx_data,
        input  ram_ce, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/codeload_ctrl.sv
// Boot sequencer: optionally loads a length-prefixed program image from the UART into code RAM,
// acknowledges with an XOR checksum, then releases the core and hands it the RAM port.
module codeload_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       skip_load,
    codeload_if.master bus,
    output logic       core_rst_n,
    output logic       load_busy,
    output logic       load_error
);
    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [32:0]     MAX_WORDS = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_ACK, S_RUN, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   wc_q, wc_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   idx_q, idx_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          got_q, got_d;
    logic          wr_q, wr_d;
    logic          sent_q, sent_d;
    logic          crst_q;

    logic          loading, byte_ok, timeout, last_wr;
    logic [31:0]   len_full;

    assign loading  = (state_q == S_LEN) || (state_q == S_DATA);
    assign byte_ok  = loading && bus.rx_data_valid && !bus.rx_error;
    assign len_full = {bus.rx_data, wc_q[31:8]};
    // The watchdog only arms once the first length byte has been seen.
    assign timeout  = loading && got_q && !bus.rx_data_valid && (tmo_q == TMO_LAST);
    assign last_wr  = wr_q && (idx_q == wc_q - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = skip_load ? S_RUN : S_LEN;
            S_LEN: begin
                if (bus.rx_error || timeout) begin
                    state_d = S_ERR;
                end else if (byte_ok && (bcnt_q == 2'd3)) begin
                    if (len_full == 32'd0)                   state_d = S_ACK;
                    else if ({1'b0, len_full} > MAX_WORDS)   state_d = S_ERR;
                    else                                     state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.rx_error || timeout) state_d = S_ERR;
                else if (last_wr)            state_d = S_ACK;
            end
            S_ACK:   if (!bus.tx_busy) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Bytes shift in LSB first; the write pulse is the cycle after the 4th data byte.
    always_comb begin
        wc_d   = wc_q;
        word_d = word_q;
        idx_d  = idx_q;
        bcnt_d = bcnt_q;
        csum_d = csum_q;
        tmo_d  = tmo_q;
        got_d  = got_q;
        wr_d   = 1'b0;
        sent_d = sent_q;
        if (byte_ok) begin
            csum_d = csum_q ^ bus.rx_data;
            bcnt_d = bcnt_q + 2'd1;
            tmo_d  = '0;
            got_d  = 1'b1;
            if (state_q == S_LEN) begin
                wc_d = len_full;
                if (bcnt_q == 2'd3) idx_d = 32'd0;
            end else begin
                word_d = {bus.rx_data, word_q[31:8]};
                wr_d   = (bcnt_q == 2'd3);
            end
        end else if (loading && got_q) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (wr_q) idx_d = idx_q + 32'd1;
        if ((state_q == S_ERR) && !bus.tx_busy) sent_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q   <= '0;
            word_q <= '0;
            idx_q  <= '0;
            bcnt_q <= '0;
            csum_q <= '0;
            tmo_q  <= '0;
            got_q  <= 1'b0;
            wr_q   <= 1'b0;
            sent_q <= 1'b0;
            crst_q <= 1'b0;
        end else begin
            wc_q   <= wc_d;
            word_q <= word_d;
            idx_q  <= idx_d;
            bcnt_q <= bcnt_d;
            csum_q <= csum_d;
            tmo_q  <= tmo_d;
            got_q  <= got_d;
            wr_q   <= wr_d;
            sent_q <= sent_d;
            crst_q <= (state_q == S_RUN);
        end
    end

    always_comb begin
        load_busy         = loading;
        load_error        = (state_q == S_ERR);
        core_rst_n        = crst_q;
        bus.tx_data_valid = 1'b0;
        bus.tx_data       = 8'h00;
        bus.ram_ce        = 1'b0;
        bus.ram_we        = 1'b0;
        bus.ram_addr      = '0;
        bus.ram_wdata     = 32'd0;
        case (state_q)
            S_RUN: begin
                bus.ram_ce    = bus.core_ce;
                bus.ram_we    = bus.core_we;
                bus.ram_addr  = bus.core_addr;
                bus.ram_wdata = bus.core_wdata;
            end
            S_DATA: begin
                if (wr_q) begin
                    bus.ram_ce    = 1'b1;
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = idx_q[ADDR_WIDTH-1:0];
                    bus.ram_wdata = word_q;
                end
            end
            S_ACK: begin
                if (!bus.tx_busy) begin
                    bus.tx_data_valid = 1'b1;
                    bus.tx_data       = csum_q;
                end
            end
            S_ERR: begin
                if (!bus.tx_busy && !sent_q) begin
                    bus.tx_data_valid = 1'b1;
                    bus.tx_data       = 8'hEE;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_codeload_ctrl.sv
// Bench for codeload_ctrl: directed boot scenarios plus randomized images, compared every cycle
// against an image-level reference model of the loader.
module tb_codeload_ctrl;
    localparam int AW  = 12;
    localparam int TMO = 200;
    localparam int P_IDLE = 0, P_LEN = 1, P_DATA = 2, P_ACK = 3, P_RUN = 4, P_ERR = 5;

    logic clk, rst_n, skip_load;
    logic core_rst_n, load_busy, load_error;

    codeload_if #(.ADDR_WIDTH(AW)) ifc ();

    codeload_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .skip_load  (skip_load),
        .bus        (ifc),
        .core_rst_n (core_rst_n),
        .load_busy  (load_busy),
        .load_error (load_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests, n_fail;
    bit busy_mode, busy_force, core_mode;
    logic [AW+31:0] wr_log[$];
    logic [7:0]     tx_log[$];

    // Reference model: the image is a byte list; everything else is derived from it.
    int         m_phase, m_idle, m_pend, m_run_age;
    bit         m_sent;
    longint     m_len;
    logic [7:0] m_xor;
    logic [7:0] m_img[$];

    function automatic logic [31:0] m_word(input int k);
        return {m_img[4*k+7], m_img[4*k+6], m_img[4*k+5], m_img[4*k+4]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int wr_now;
        if (!rst_n) begin
            m_phase = P_IDLE; m_img.delete(); m_xor = 8'h00; m_idle = 0;
            m_pend = -1; m_run_age = 0; m_sent = 1'b0; m_len = 0;
        end else begin
            wr_now = m_pend;
            m_pend = -1;
            case (m_phase)
                P_IDLE: m_phase = skip_load ? P_RUN : P_LEN;
                P_LEN, P_DATA: begin
                    if (ifc.rx_error) begin
                        m_phase = P_ERR;
                    end else if (ifc.rx_data_valid) begin
                        m_img.push_back(ifc.rx_data);
                        m_xor = m_xor ^ ifc.rx_data;
                        m_idle = 0;
                        if (m_phase == P_LEN && m_img.size() == 4) begin
                            m_len = longint'({m_img[3], m_img[2], m_img[1], m_img[0]});
                            if (m_len == 0)                m_phase = P_ACK;
                            else if (m_len > (1 << AW))    m_phase = P_ERR;
                            else                           m_phase = P_DATA;
                        end else if (m_phase == P_DATA && (m_img.size() - 4) % 4 == 0) begin
                            m_pend = (m_img.size() - 4) / 4 - 1;
                        end
                    end else if (m_img.size() > 0) begin
                        m_idle++;
                        if (m_idle >= TMO) m_phase = P_ERR;
                    end
                    if (m_phase == P_DATA && wr_now >= 0 && longint'(wr_now) == m_len - 1) m_phase = P_ACK;
                end
                P_ACK: if (!ifc.tx_busy) m_phase = P_RUN;
                P_RUN: m_run_age++;
                P_ERR: if (!ifc.tx_busy) m_sent = 1'b1;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic evld, ece, ewe;
        logic [7:0] etx;
        logic [AW-1:0] ea;
        logic [31:0] ed;
        evld = 1'b0; etx = 8'h00; ece = 1'b0; ewe = 1'b0; ea = '0; ed = 32'd0;
        if (m_phase == P_RUN) begin
            ece = ifc.core_ce; ewe = ifc.core_we; ea = ifc.core_addr; ed = ifc.core_wdata;
        end else if (m_phase == P_DATA && m_pend >= 0) begin
            ece = 1'b1; ewe = 1'b1; ea = AW'(m_pend); ed = m_word(m_pend);
        end
        if (m_phase == P_ACK && !ifc.tx_busy) begin
            evld = 1'b1; etx = m_xor;
        end else if (m_phase == P_ERR && !ifc.tx_busy && !m_sent) begin
            evld = 1'b1; etx = 8'hEE;
        end
        check("load_busy", load_busy, (m_phase == P_LEN) || (m_phase == P_DATA));
        check("load_error", load_error, m_phase == P_ERR);
        check("core_rst_n", core_rst_n, (m_phase == P_RUN) && (m_run_age > 0));
        check("ram_ce", ifc.ram_ce, ece);
        check("ram_we", ifc.ram_we, ewe);
        check("ram_addr", ifc.ram_addr, ea);
        check("ram_wdata", ifc.ram_wdata, ed);
        check("tx_data_valid", ifc.tx_data_valid, evld);
        check("tx_data", ifc.tx_data, etx);
        if (ifc.ram_ce && ifc.ram_we) wr_log.push_back({ifc.ram_addr, ifc.ram_wdata});
        if (ifc.tx_data_valid) tx_log.push_back(ifc.tx_data);
    endtask

    // One clock: check outputs mid-cycle, pass the edge, then drive the next cycle's inputs.
    task automatic tick();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
        ifc.tx_busy = busy_mode ? busy_force : ($urandom_range(0, 2) == 0);
        if (!core_mode) begin
            ifc.core_ce    = 1'($urandom);
            ifc.core_we    = 1'($urandom);
            ifc.core_addr  = AW'($urandom);
            ifc.core_wdata = $urandom;
        end
        ifc.rx_data_valid = 1'b0;
        ifc.rx_error      = 1'b0;
        ifc.rx_data       = 8'($urandom);
    endtask

    task automatic do_reset(input bit skip);
        rst_n = 1'b0;
        repeat (2) tick();
        skip_load = skip;
        rst_n = 1'b1;
        wr_log.delete();
        tx_log.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        ifc.rx_data_valid = 1'b1;
        ifc.rx_data       = b;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
    endtask

    task automatic wait_settle(input string nm, input int bound);
        int n;
        n = 0;
        while (!(core_rst_n || load_error) && n < bound) begin
            tick();
            n++;
        end
        check(nm, core_rst_n || load_error, 1);
    endtask

    task automatic run_random(input int iters);
        bit skip;
        int len, errpos, gap;
        logic [31:0] lw;
        logic [7:0] img[$];
        for (int it = 0; it < iters; it++) begin
            busy_mode = 1'b0;
            core_mode = 1'b0;
            skip = ($urandom_range(0, 9) == 0);
            do_reset(skip);
            tick();
            if (!skip) begin
                case ($urandom_range(0, 9))
                    0:       len = 4097 + $urandom_range(0, 100000);
                    1:       len = 0;
                    default: len = $urandom_range(1, 5);
                endcase
                lw = 32'(len);
                img.delete();
                for (int i = 0; i < 4; i++) img.push_back(lw[8*i +: 8]);
                if (len <= 4096) for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
                errpos = ($urandom_range(0, 5) == 0) ? $urandom_range(0, img.size() - 1) : -1;
                for (int i = 0; i < img.size(); i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) tick();
                    ifc.rx_data_valid = 1'b1;
                    ifc.rx_data       = img[i];
                    if (i == errpos) begin
                        ifc.rx_error = 1'b1;
                        tick();
                        break;
                    end
                    tick();
                end
            end
            wait_settle("rand_settle", 300);
            repeat (6) begin
                ifc.rx_data_valid = 1'($urandom);
                ifc.rx_error      = 1'($urandom);
                ifc.rx_data       = 8'($urandom);
                tick();
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; skip_load = 1'b0;
        busy_mode = 1'b1; busy_force = 1'b0; core_mode = 1'b1;
        ifc.rx_data_valid = 1'b0; ifc.rx_error = 1'b0; ifc.rx_data = 8'h00; ifc.tx_busy = 1'b0;
        ifc.core_ce = 1'b0; ifc.core_we = 1'b0; ifc.core_addr = '0; ifc.core_wdata = 32'd0;
        repeat (2) tick();
        check("reset_ram_ce", ifc.ram_ce, 0);
        check("reset_core_rst_n", core_rst_n, 0);
        check("reset_tx_valid", ifc.tx_data_valid, 0);

        // Strap skip: straight to RUN, RAM port follows the core.
        ifc.core_ce = 1'b1; ifc.core_we = 1'b0; ifc.core_addr = 12'h123; ifc.core_wdata = 32'hCAFEF00D;
        do_reset(1'b1);
        repeat (2) tick();
        check("skip_core_rst_n", core_rst_n, 1);
        check("skip_ram_ce", ifc.ram_ce, 1);
        check("skip_ram_addr", ifc.ram_addr, 12'h123);
        ifc.core_addr = 12'h2AB;
        #1;
        check("skip_mux_same_cycle", ifc.ram_addr, 12'h2AB);
        repeat (4) tick();
        check("skip_no_writes", wr_log.size(), 0);
        check("skip_no_tx", tx_log.size(), 0);

        // Two-word image, back-to-back bytes.
        ifc.core_ce = 1'b0; ifc.core_we = 1'b0; ifc.core_addr = '0; ifc.core_wdata = 32'd0;
        do_reset(1'b0);
        tick();
        send_word(32'h0000_0002);
        send_word(32'hDEAD_BEEF);
        send_word(32'h1234_5678);
        wait_settle("img_settle", 100);
        repeat (2) tick();
        check("img_nwr", wr_log.size(), 2);
        check("img_w0", (wr_log.size() > 0) ? wr_log[0] : '1, {12'h000, 32'hDEADBEEF});
        check("img_w1", (wr_log.size() > 1) ? wr_log[1] : '1, {12'h001, 32'h12345678});
        check("img_ntx", tx_log.size(), 1);
        check("img_tx", (tx_log.size() > 0) ? tx_log[0] : 8'hFF, 8'h28);
        check("img_core_rst_n", core_rst_n, 1);

        // Oversized length: error, 0xEE once after tx_busy clears.
        do_reset(1'b0);
        tick();
        busy_force = 1'b1;
        send_word(32'h0000_1001);
        repeat (5) tick();
        check("len_err_no_tx_while_busy", tx_log.size(), 0);
        busy_force = 1'b0;
        repeat (10) tick();
        check("len_err_flag", load_error, 1);
        check("len_err_ntx", tx_log.size(), 1);
        check("len_err_tx", (tx_log.size() > 0) ? tx_log[0] : 8'h00, 8'hEE);
        check("len_err_core_rst_n", core_rst_n, 0);
        check("len_err_nwr", wr_log.size(), 0);

        // Zero length: ack 0x00, no writes.
        do_reset(1'b0);
        tick();
        send_word(32'h0);
        wait_settle("zero_settle", 50);
        tick();
        check("zero_ntx", tx_log.size(), 1);
        check("zero_tx", (tx_log.size() > 0) ? tx_log[0] : 8'hFF, 8'h00);
        check("zero_nwr", wr_log.size(), 0);
        check("zero_core_rst_n", core_rst_n, 1);

        // Inter-byte timeout.
        do_reset(1'b0);
        tick();
        send_word(32'h1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        repeat (TMO - 1) tick();
        check("tmo_before_err", load_error, 0);
        check("tmo_before_busy", load_busy, 1);
        tick();
        check("tmo_at_err", load_error, 1);

        // rx_error mid-word.
        do_reset(1'b0);
        tick();
        send_word(32'h1);
        send_byte(8'h11, 0);
        ifc.rx_data_valid = 1'b1; ifc.rx_data = 8'h22; ifc.rx_error = 1'b1;
        tick();
        check("rxerr_flag", load_error, 1);
        check("rxerr_busy", load_busy, 0);

        // ACK held off by tx_busy.
        do_reset(1'b0);
        tick();
        busy_force = 1'b1;
        send_word(32'h0);
        repeat (50) tick();
        check("ackbusy_no_tx", tx_log.size(), 0);
        check("ackbusy_core_rst_n", core_rst_n, 0);
        busy_force = 1'b0;
        repeat (4) tick();
        check("ackbusy_ntx", tx_log.size(), 1);
        check("ackbusy_core_rst_n_after", core_rst_n, 1);

        // Asynchronous reset during a write pulse, then a clean reload.
        do_reset(1'b0);
        tick();
        send_word(32'h2);
        send_word(32'hA5A5_0F0F);
        check("mid_pulse_ce", ifc.ram_ce, 1);
        check("mid_pulse_wdata", ifc.ram_wdata, 32'hA5A5_0F0F);
        rst_n = 1'b0;
        #1;
        check("async_rst_ram_ce", ifc.ram_ce, 0);
        check("async_rst_ram_wdata", ifc.ram_wdata, 0);
        check("async_rst_busy", load_busy, 0);
        do_reset(1'b0);
        tick();
        send_word(32'h2);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        wait_settle("reload_settle", 100);
        tick();
        check("reload_nwr", wr_log.size(), 2);
        check("reload_w1", (wr_log.size() > 1) ? wr_log[1] : '1, {12'h001, 32'h22222222});
        check("reload_tx", (tx_log.size() > 0) ? tx_log[0] : 8'hFF, 8'h02);

        run_random(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "bench did not finish in time");
    end
endmodule
